// File: rtl/fir_pkg.sv
// Shared FIR definitions: default geometry and the sample-streamer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

  localparam int FIR_LENGTH      = 20;  // tap count
  localparam int FIR_DATA_WIDTH  = 8;   // signed sample width
  localparam int FIR_MAX_SAMPLES = 64;  // sample RAM depth

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_COEFF = 3'd1,
    ST_ARM        = 3'd2,
    ST_STREAM     = 3'd3,
    ST_PAD        = 3'd4,
    ST_DONE       = 3'd5
  } streamer_state_t;

endpackage

// File: rtl/fir_sample_ram.sv
// Sample store: one write port plus one synchronous read port, array not reset.
// Latency: read data is valid one clock after the read address is presented.
// Backpressure: none; the owner gates the write strobe.
// Ports: clock; we/waddr/wdata write side; raddr in, rdata registered out.
module fir_sample_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = 6
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_data_streamer.sv
// Streams stored samples into n_tap_fir, then LENGTH-1 zero pads for a full convolution.
// Latency: first sample on dataOut two clocks after the edge that sees start with coeffSetFlag high.
// Backpressure: none downstream; waits on coeffSetFlag, ignores start and RAM writes while streaming.
// Ports: clock, reset (sync, active-high); wrEnable/wrAddr/wrData load the RAM;
//        numSamples/start/coeffSetFlag control a run; loadDataFlag/dataOut/busy/done are registered outputs.
module fir_data_streamer
  import fir_pkg::*;
#(
  parameter int LENGTH      = FIR_LENGTH,
  parameter int DATA_WIDTH  = FIR_DATA_WIDTH,
  parameter int MAX_SAMPLES = FIR_MAX_SAMPLES,
  parameter int ADDR_WIDTH  = $clog2(MAX_SAMPLES)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wrEnable,
  input  logic [ADDR_WIDTH-1:0]        wrAddr,
  input  logic signed [DATA_WIDTH-1:0] wrData,
  input  logic [ADDR_WIDTH:0]          numSamples,
  input  logic                         start,
  input  logic                         coeffSetFlag,
  output logic                         loadDataFlag,
  output logic signed [DATA_WIDTH-1:0] dataOut,
  output logic                         busy,
  output logic                         done
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int PAD_W = (LENGTH > 2) ? $clog2(LENGTH) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PAD_W-1:0] PAD_ONE  = PAD_W'(1);
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'((LENGTH >= 2) ? (LENGTH - 2) : 0);

  streamer_state_t state_q, state_d;

  logic [CNT_W-1:0]      idx_q;    // next RAM address to read
  logic [CNT_W-1:0]      count_q;  // samples in this run
  logic [PAD_W-1:0]      pad_q;    // pads emitted so far
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic accept;
  logic last_sample;
  logic streaming;

  assign accept      = (state_q == ST_IDLE) && start && (numSamples != '0);
  // idx runs one ahead of the sample on the RAM output, so it equals count on the last STREAM cycle.
  assign last_sample = (idx_q == count_q);
  assign streaming   = (state_q == ST_ARM) || (state_q == ST_STREAM) || (state_q == ST_PAD);

  // Writes are blocked while the stream owns the RAM so a run always sees a stable image.
  fir_sample_ram #(
    .DEPTH (MAX_SAMPLES),
    .WIDTH (DATA_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (wrEnable && !streaming),
    .waddr (wrAddr),
    .wdata (wrData),
    .raddr (idx_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = coeffSetFlag ? ST_ARM : ST_WAIT_COEFF;
        end
      end
      ST_WAIT_COEFF: begin
        if (coeffSetFlag) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM:    state_d = ST_STREAM;
      ST_STREAM: begin
        if (last_sample) begin
          state_d = (LENGTH > 1) ? ST_PAD : ST_DONE;
        end
      end
      ST_PAD: begin
        if (pad_q == PAD_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= '0;
      count_q <= '0;
      pad_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (accept) begin
            count_q <= (numSamples > CNT_MAX) ? CNT_MAX : numSamples;
          end
        end
        ST_ARM: idx_q <= idx_q + CNT_ONE;
        ST_STREAM: begin
          pad_q <= '0;
          if (!last_sample) begin
            idx_q <= idx_q + CNT_ONE;
          end
        end
        ST_PAD: pad_q <= pad_q + PAD_ONE;
        default: ;
      endcase
    end
  end

  // Outputs follow the state of the previous cycle, which also absorbs the RAM read latency.
  logic                  load_d;
  logic                  busy_d;
  logic                  done_d;
  logic [DATA_WIDTH-1:0] data_d;

  always_comb begin
    load_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    data_d = '0;
    case (state_q)
      ST_ARM: begin
        load_d = 1'b1;
        busy_d = 1'b1;
      end
      ST_STREAM: begin
        load_d = 1'b1;
        busy_d = 1'b1;
        data_d = ram_rdata;
      end
      ST_PAD: begin
        load_d = 1'b1;
        busy_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      loadDataFlag <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dataOut      <= '0;
    end else begin
      loadDataFlag <= load_d;
      busy         <= busy_d;
      done         <= done_d;
      dataOut      <= data_d;
    end
  end

endmodule

// File: doc/fir_data_streamer.md
# fir_data_streamer

Sample source for `n_tap_fir`: the transmitting end of its data interface. Holds up to MAX_SAMPLES signed samples in an internal RAM and, on `start`, waits for `coeffSetFlag` from `setup_FIR_coeff`, raises `loadDataFlag`, and streams the samples one per clock. It then appends LENGTH-1 zero pads so the filter output is a full linear convolution. This replaces hand-written stimulus sequences and makes FIR runs repeatable in simulation and on hardware.

## Interface
- LENGTH, 20, FIR tap count; number of zero pads = LENGTH-1
- DATA_WIDTH, 8, signed sample width
- MAX_SAMPLES, 64, RAM depth
- ADDR_WIDTH, 6, clog2(MAX_SAMPLES); count ports are ADDR_WIDTH+1 bits
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- wrEnable  in  1  RAM write strobe; ignored while busy
- wrAddr  in  ADDR_WIDTH  RAM write address
- wrData  in  DATA_WIDTH  signed sample to write
- numSamples  in  ADDR_WIDTH+1  samples to stream; latched on accepted start
- start  in  1  level/pulse request; sampled only in IDLE
- coeffSetFlag  in  1  coefficients loaded in the FIR
- loadDataFlag  out  1  to FIR loadDataFlag; reset 0
- dataOut  out  DATA_WIDTH  signed, to FIR dataIn; reset 0
- busy  out  1  high from ARM through the last pad; reset 0
- done  out  1  one-cycle completion pulse; reset 0

## Operation
- States: IDLE, WAIT_COEFF, ARM, STREAM, PAD, DONE.
- IDLE: a start with numSamples==0 is ignored. Otherwise latch count = min(numSamples, MAX_SAMPLES). Go to ARM if coeffSetFlag=1, else to WAIT_COEFF.
- WAIT_COEFF: hold until coeffSetFlag=1, then go to ARM. busy=0 here and RAM writes are still accepted.
- ARM: one cycle with loadDataFlag=1 and dataOut=0.
- STREAM: count cycles; dataOut = mem[idx], idx 0..count-1.
- PAD: LENGTH-1 cycles with dataOut=0 and loadDataFlag=1.
- DONE: one cycle with done=1, loadDataFlag=0, busy=0, dataOut=0. Then IDLE.
- coeffSetFlag falling after ARM is ignored.
- start during busy is ignored.
- All outputs are registered.
- RAM contents are not cleared by reset.
- Reset mid-operation: next cycle is IDLE with all outputs 0. No done pulse.
- Write in the same cycle as an accepted start: the write takes effect and is visible to the stream.
- No arithmetic beyond counters. Counters are ADDR_WIDTH+1 bits for samples and clog2(LENGTH) bits for pads; both are never wrapped.

## Timing
- Let the accepted start be at edge t, with coeffSetFlag=1.
- ARM is visible after edge t.
- mem[i] is on dataOut after edge t+2+i.
- Pads are visible after edges t+2+N through t+N+LENGTH.
- done is high after edge t+N+LENGTH+1.
- Total busy length: 1+N+LENGTH-1 cycles.
- RAM read is synchronous: the address is issued one cycle ahead, so the ARM cycle covers the read latency.
- WAIT_COEFF adds exactly the number of cycles coeffSetFlag is low, plus 0 (transition occurs on the edge that samples it high).

## Structure
- Package `fir_pkg`: default LENGTH, DATA_WIDTH, MAX_SAMPLES; state encoding enum for this FSM. Shared with `n_tap_fir` and `setup_FIR_coeff`.
- Sub-module `fir_sample_ram`: single-port write plus synchronous-read RAM, MAX_SAMPLES x DATA_WIDTH, no reset on the array.
- Top level: FSM, counters and output registers.

## Test plan
- Load 10,20,30 into addresses 0..2, numSamples=3, coeffSetFlag=1, pulse start -> loadDataFlag high for 1+3+19=23 cycles; dataOut = 0,10,20,30 then 19 zeros; done one cycle later.
- Same RAM with coeffSetFlag held 0 for 7 cycles after start -> stream begins exactly 7 cycles late; busy stays 0 until ARM.
- Negative samples -126, 127, -1 -> dataOut sign-correct bit patterns 0x82, 0x7F, 0xFF.
- numSamples=100 (greater than MAX_SAMPLES=64) -> 64 samples streamed, then 19 pads.
- reset asserted on the 5th STREAM cycle -> next cycle IDLE with all outputs 0 and no done. A restart then replays from mem[0] with RAM intact.
- start pulsed during PAD, plus writes attempted during STREAM -> no restart, and the RAM is unchanged (read back on the next run).
